sprite_layer_renderer: RTL and testbench
========================================

// Module: sprite_layer_renderer
// PURPOSE
// Parametrised multi-slot sprite layer for the scrolling playfield (spikes, blocks, pads).
// Per VGA pixel: finds the highest-priority enabled slot covering (DrawX,DrawY) in world space.
// Generates the sprite ROM address and emits a palette index plus a valid flag, 2 cycles later.
// Slot registers are double-buffered and committed at frame start (no tearing).
// Scroll position advances once per frame. The palette LUT and RGB mux sit downstream.
// PARAMETERS
// NUM_SLOTS    4     number of independent sprite slots; slot 0 has the highest priority
// NUM_SPRITES  4     sprite images stored back-to-back in the ROM
// SPR_W        32    sprite width in pixels (power of 2)
// SPR_H        32    sprite height in pixels (power of 2)
// IDX_W        4     palette index width (rom_q width)
// TRANSP_IDX   0     palette index treated as transparent
// X_W          11    world x / scroll width in bits; world space wraps modulo 2**X_W
// ADDR_W       12    ROM address width; must be >= clog2(NUM_SPRITES*SPR_W*SPR_H)
// PORTS
// vga_clk       in   1          pixel clock; all state on posedge
// reset_n       in   1          synchronous, active-low reset
// DrawX         in   10         current pixel x
// DrawY         in   10         current pixel y
// blank         in   1          1 = active video
// frame_start   in   1          1-cycle pulse, once per frame, during vertical blanking
// run           in   1          1 = scrolling enabled
// scroll_speed  in   4          pixels added to scroll_pos per frame
// slot_wr       in   1          write strobe into the shadow slot registers
// slot_sel      in   clog2(NUM_SLOTS)     slot to write
// slot_en       in   1          slot enable
// slot_x        in   X_W        slot world x (left edge)
// slot_y        in   10         slot screen y (top edge)
// slot_spr      in   clog2(NUM_SPRITES)   sprite image id for the slot
// rom_address   out  ADDR_W     to sync ROM; ROM has 1-cycle read latency
// rom_q         in   IDX_W      ROM data
// pix_idx       out  IDX_W      palette index (0 when pix_valid=0)
// pix_valid     out  1          opaque sprite pixel present
// pix_slot      out  clog2(NUM_SLOTS)    winning slot (0 when pix_valid=0)
// scroll_pos    out  X_W        current scroll offset
// BEHAVIOUR
// - Reset (reset_n=0 at posedge):
//   - shadow and active slots cleared: en=0, x=0, y=0, spr=0
//   - scroll_pos=0; pipeline valid bits=0; rom_address=0; pix_idx=0; pix_valid=0; pix_slot=0
// - Reset asserted mid-frame: the pipeline is flushed; outputs stay 0 until 2 edges after release.
// - slot_wr=1: the shadow slot[slot_sel] takes {en,x,y,spr}. Active slots are unchanged.
// - frame_start=1:
//   - all shadow slots are copied to the active slots
//   - if slot_wr is high in the same cycle, the new write is included in the commit (forwarded)
//   - if run=1: scroll_pos <= scroll_pos + scroll_speed, mod 2**X_W (wraps, no saturation)
// - Hit test, combinational on DrawX/DrawY against the active slots, for each slot i:
//   - lx = (DrawX + scroll_pos - x_i) mod 2**X_W
//   - ly = (DrawY - y_i) mod 2**10
//   - hit_i = en_i && lx < SPR_W && ly < SPR_H
//   - the lowest i with hit_i wins
// - Stage A (edge n): registers {hit_any, win slot, lx, ly, spr of winner, blank}.
// - rom_address = spr*SPR_W*SPR_H + ly*SPR_W + lx
//   - combinational from the stage A registers
//   - is 0 when hit_any=0
// - Stage B (edge n+1): the ROM latches the address; stage B registers the stage A control bits.
// - Output (edge n+2):
//   - pix_valid = blankB && hitB && (rom_q != TRANSP_IDX)
//   - pix_idx = pix_valid ? rom_q : 0
//   - pix_slot = pix_valid ? slotB : 0
// - Total latency from the DrawX sample to the outputs: 2 cycles. The caller delays blank/RGB to match.
// - Transparency does not fall through to lower-priority slots: if the winner's pixel is transparent, pix_valid=0.
// - Sprites straddling the world wrap (x near 2**X_W-1) render correctly because lx uses modular arithmetic.
// - Sprites partially past the right screen edge are clipped naturally; no special case.
// TESTING
// - Reset, then slot0 {en=1,x=100,y=200,spr=1} written + frame_start, run=0; DrawX=100,DrawY=200:
//   rom_address=1024 one edge after the sample; pix_valid=1 two edges after the sample, if rom_q!=0.
// - Slot0 and slot2 both cover (50,50); pix_slot=0. Set slot0 en=0, commit: pix_slot=2.
// - slot_wr without frame_start: output unchanged. Write in the same cycle as frame_start: new value used in the next frame.
// - run=1, scroll_speed=4, scroll_pos=2046 (X_W=11): after one frame_start, scroll_pos=2.
//   A slot with x=0 covers DrawX=0..29 after the wrap (lx: 2..31).
// - rom_q=TRANSP_IDX on a hit pixel: pix_valid=0, pix_idx=0. blank=0 on a hit pixel: pix_valid=0.
// - Pull reset_n low for 1 cycle mid-line: all outputs=0, slots disabled, scroll_pos=0.

Source files
------------

// File: rtl/sprite_layer_renderer_if.sv
// ============================================================================
// Module      : sprite_layer_renderer_if
// Description : Slot-programming bus into the sprite layer's shadow registers.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface sprite_layer_renderer_if #(
  parameter int NUM_SLOTS   = 4,
  parameter int NUM_SPRITES = 4,
  parameter int X_W         = 11
);
  localparam int SEL_W   = (NUM_SLOTS   > 1) ? $clog2(NUM_SLOTS)   : 1;
  localparam int SPRID_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  logic               slot_wr;
  logic [SEL_W-1:0]   slot_sel;
  logic               slot_en;
  logic [X_W-1:0]     slot_x;
  logic [9:0]         slot_y;
  logic [SPRID_W-1:0] slot_spr;

  modport master (
    output slot_wr, slot_sel, slot_en, slot_x, slot_y, slot_spr
  );

  modport slave (
    input  slot_wr, slot_sel, slot_en, slot_x, slot_y, slot_spr
  );
endinterface

`default_nettype wire

// File: rtl/sprite_layer_renderer.sv
// ============================================================================
// Module      : sprite_layer_renderer
// Description : Multi-slot scrolling sprite layer; emits palette index 2 cycles
//               after the pixel coordinate is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sprite_layer_renderer #(
  parameter int NUM_SLOTS   = 4,
  parameter int NUM_SPRITES = 4,
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 32,
  parameter int IDX_W       = 4,
  parameter int TRANSP_IDX  = 0,
  parameter int X_W         = 11,
  parameter int ADDR_W      = 12,
  localparam int SEL_W      = (NUM_SLOTS   > 1) ? $clog2(NUM_SLOTS)   : 1,
  localparam int SPRID_W    = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  wire logic                 vga_clk,
  input  wire logic                 reset_n,
  input  wire logic [9:0]           DrawX,
  input  wire logic [9:0]           DrawY,
  input  wire logic                 blank,
  input  wire logic                 frame_start,
  input  wire logic                 run,
  input  wire logic [3:0]           scroll_speed,
  sprite_layer_renderer_if.slave    slot_bus,
  output logic      [ADDR_W-1:0]    rom_address,
  input  wire logic [IDX_W-1:0]     rom_q,
  output logic      [IDX_W-1:0]     pix_idx,
  output logic                      pix_valid,
  output logic      [SEL_W-1:0]     pix_slot,
  output logic      [X_W-1:0]       scroll_pos
);

  localparam int LX_W = $clog2(SPR_W);
  localparam int LY_W = $clog2(SPR_H);

  localparam logic [X_W-1:0]   c_spr_w  = X_W'(SPR_W);
  localparam logic [9:0]       c_spr_h  = 10'(SPR_H);
  localparam logic [IDX_W-1:0] c_transp = IDX_W'(TRANSP_IDX);

  // Shadow slots take CPU writes; active slots are what the hit test sees.
  logic               r_sh_en  [NUM_SLOTS];
  logic [X_W-1:0]     r_sh_x   [NUM_SLOTS];
  logic [9:0]         r_sh_y   [NUM_SLOTS];
  logic [SPRID_W-1:0] r_sh_spr [NUM_SLOTS];

  logic               r_act_en  [NUM_SLOTS];
  logic [X_W-1:0]     r_act_x   [NUM_SLOTS];
  logic [9:0]         r_act_y   [NUM_SLOTS];
  logic [SPRID_W-1:0] r_act_spr [NUM_SLOTS];

  logic [X_W-1:0]     r_scroll;

  logic [NUM_SLOTS-1:0] w_wr_sel;
  logic [NUM_SLOTS-1:0] w_hit;
  logic [X_W-1:0]       w_lx [NUM_SLOTS];
  logic [9:0]           w_ly [NUM_SLOTS];

  logic               w_win_hit;
  logic [SEL_W-1:0]   w_win_slot;
  logic [LX_W-1:0]    w_win_lx;
  logic [LY_W-1:0]    w_win_ly;
  logic [SPRID_W-1:0] w_win_spr;

  logic               r_a_hit;
  logic [SEL_W-1:0]   r_a_slot;
  logic [LX_W-1:0]    r_a_lx;
  logic [LY_W-1:0]    r_a_ly;
  logic [SPRID_W-1:0] r_a_spr;
  logic               r_a_blank;

  logic               r_b_hit;
  logic [SEL_W-1:0]   r_b_slot;
  logic               r_b_blank;

  logic               w_opaque;
  logic [IDX_W-1:0]   r_pix_idx;
  logic               r_pix_valid;
  logic [SEL_W-1:0]   r_pix_slot;

  // Per-slot write decode and world-space hit test; lx wraps so sprites
  // straddling the world seam still render.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    assign w_wr_sel[gi] = slot_bus.slot_wr && (slot_bus.slot_sel == SEL_W'(gi));
    assign w_lx[gi]     = X_W'(DrawX) + r_scroll - r_act_x[gi];
    assign w_ly[gi]     = DrawY - r_act_y[gi];
    assign w_hit[gi]    = r_act_en[gi] && (w_lx[gi] < c_spr_w) && (w_ly[gi] < c_spr_h);
  end

  always_comb begin
    w_win_hit  = 1'b0;
    w_win_slot = '0;
    w_win_lx   = '0;
    w_win_ly   = '0;
    w_win_spr  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_win_hit  = 1'b1;
        w_win_slot = SEL_W'(i);
        w_win_lx   = w_lx[i][LX_W-1:0];
        w_win_ly   = w_ly[i][LY_W-1:0];
        w_win_spr  = r_act_spr[i];
      end
    end
  end

  // A write coinciding with frame_start is forwarded into the commit.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_sh_en[i]   <= 1'b0;
        r_sh_x[i]    <= '0;
        r_sh_y[i]    <= '0;
        r_sh_spr[i]  <= '0;
        r_act_en[i]  <= 1'b0;
        r_act_x[i]   <= '0;
        r_act_y[i]   <= '0;
        r_act_spr[i] <= '0;
      end
      r_scroll <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (w_wr_sel[i]) begin
          r_sh_en[i]  <= slot_bus.slot_en;
          r_sh_x[i]   <= slot_bus.slot_x;
          r_sh_y[i]   <= slot_bus.slot_y;
          r_sh_spr[i] <= slot_bus.slot_spr;
        end
        if (frame_start) begin
          r_act_en[i]  <= w_wr_sel[i] ? slot_bus.slot_en  : r_sh_en[i];
          r_act_x[i]   <= w_wr_sel[i] ? slot_bus.slot_x   : r_sh_x[i];
          r_act_y[i]   <= w_wr_sel[i] ? slot_bus.slot_y   : r_sh_y[i];
          r_act_spr[i] <= w_wr_sel[i] ? slot_bus.slot_spr : r_sh_spr[i];
        end
      end
      if (frame_start && run) begin
        r_scroll <= r_scroll + X_W'(scroll_speed);
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_a_hit   <= 1'b0;
      r_a_slot  <= '0;
      r_a_lx    <= '0;
      r_a_ly    <= '0;
      r_a_spr   <= '0;
      r_a_blank <= 1'b0;
      r_b_hit   <= 1'b0;
      r_b_slot  <= '0;
      r_b_blank <= 1'b0;
    end else begin
      r_a_hit   <= w_win_hit;
      r_a_slot  <= w_win_slot;
      r_a_lx    <= w_win_lx;
      r_a_ly    <= w_win_ly;
      r_a_spr   <= w_win_spr;
      r_a_blank <= blank;
      r_b_hit   <= r_a_hit;
      r_b_slot  <= r_a_slot;
      r_b_blank <= r_a_blank;
    end
  end

  // Power-of-2 sprite dimensions make the address a plain field concatenation.
  assign rom_address = r_a_hit ? ADDR_W'({r_a_spr, r_a_ly, r_a_lx}) : '0;

  // A transparent winner hides lower-priority slots rather than falling through.
  assign w_opaque = r_b_blank && r_b_hit && (rom_q != c_transp);

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_pix_valid <= 1'b0;
      r_pix_idx   <= '0;
      r_pix_slot  <= '0;
    end else begin
      r_pix_valid <= w_opaque;
      r_pix_idx   <= w_opaque ? rom_q    : '0;
      r_pix_slot  <= w_opaque ? r_b_slot : '0;
    end
  end

  assign pix_valid  = r_pix_valid;
  assign pix_idx    = r_pix_idx;
  assign pix_slot   = r_pix_slot;
  assign scroll_pos = r_scroll;

endmodule

`default_nettype wire

// File: tb/tb_sprite_layer_renderer.sv
// ============================================================================
// Module      : tb_sprite_layer_renderer
// Description : Directed scoreboard bench for sprite_layer_renderer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sprite_layer_renderer;
  localparam int NUM_SLOTS   = 4;
  localparam int NUM_SPRITES = 4;
  localparam int SPR_W       = 32;
  localparam int SPR_H       = 32;
  localparam int IDX_W       = 4;
  localparam int TRANSP_IDX  = 0;
  localparam int X_W         = 11;
  localparam int ADDR_W      = 12;

  logic              vga_clk;
  logic              reset_n;
  logic [9:0]        DrawX, DrawY;
  logic              blank, frame_start, run;
  logic [3:0]        scroll_speed;
  logic [ADDR_W-1:0] rom_address;
  logic [IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]  pix_idx;
  logic              pix_valid;
  logic [1:0]        pix_slot;
  logic [X_W-1:0]    scroll_pos;

  sprite_layer_renderer_if #(.NUM_SLOTS(NUM_SLOTS), .NUM_SPRITES(NUM_SPRITES), .X_W(X_W)) slot_bus ();

  sprite_layer_renderer #(
    .NUM_SLOTS(NUM_SLOTS), .NUM_SPRITES(NUM_SPRITES), .SPR_W(SPR_W), .SPR_H(SPR_H),
    .IDX_W(IDX_W), .TRANSP_IDX(TRANSP_IDX), .X_W(X_W), .ADDR_W(ADDR_W)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .run(run), .scroll_speed(scroll_speed), .slot_bus(slot_bus),
    .rom_address(rom_address), .rom_q(rom_q), .pix_idx(pix_idx), .pix_valid(pix_valid),
    .pix_slot(pix_slot), .scroll_pos(scroll_pos)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Sprite ROM contents: lx == 7 is transparent, every other pixel is opaque.
  function automatic logic [3:0] rom_f(input logic [11:0] a);
    if (a[4:0] == 5'd7) return 4'd0;
    return (a[3:0] ^ a[8:5] ^ 4'hA) | 4'd1;
  endfunction

  always @(posedge vga_clk) rom_q <= rom_f(rom_address);

  typedef struct packed {
    logic [11:0] addr;
    logic        valid;
    logic [3:0]  idx;
    logic [1:0]  slot;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  bit m_sh_en  [NUM_SLOTS];
  int m_sh_x   [NUM_SLOTS];
  int m_sh_y   [NUM_SLOTS];
  int m_sh_spr [NUM_SLOTS];
  bit m_act_en [NUM_SLOTS];
  int m_act_x  [NUM_SLOTS];
  int m_act_y  [NUM_SLOTS];
  int m_act_spr[NUM_SLOTS];
  int m_scroll;

  function automatic void model_reset();
    for (int i = 0; i < NUM_SLOTS; i++) begin
      m_sh_en[i] = 0;  m_sh_x[i] = 0;  m_sh_y[i] = 0;  m_sh_spr[i] = 0;
      m_act_en[i] = 0; m_act_x[i] = 0; m_act_y[i] = 0; m_act_spr[i] = 0;
    end
    m_scroll = 0;
  endfunction

  function automatic void model_commit(input bit rn, input int spd);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      m_act_en[i] = m_sh_en[i]; m_act_x[i] = m_sh_x[i];
      m_act_y[i] = m_sh_y[i];   m_act_spr[i] = m_sh_spr[i];
    end
    if (rn) m_scroll = (m_scroll + spd) % (1 << X_W);
  endfunction

  function automatic exp_t model(input int x, input int y, input bit blk);
    exp_t e;
    e = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      int lx, ly;
      lx = (x + m_scroll - m_act_x[i]) & ((1 << X_W) - 1);
      ly = (y - m_act_y[i]) & 1023;
      if (m_act_en[i] && lx < SPR_W && ly < SPR_H) begin
        e.addr = 12'(m_act_spr[i] * SPR_W * SPR_H + ly * SPR_W + lx);
        if (blk && rom_f(e.addr) != 4'(TRANSP_IDX)) begin
          e.valid = 1'b1;
          e.idx   = rom_f(e.addr);
          e.slot  = 2'(i);
        end
        break;
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_out(input exp_t e);
    check("pix_valid", 32'(pix_valid), 32'(e.valid));
    check("pix_idx",   32'(pix_idx),   32'(e.idx));
    check("pix_slot",  32'(pix_slot),  32'(e.slot));
  endtask

  // One pixel per cycle; outputs lag by two edges, so the oldest entry is popped.
  task automatic step(input int x, input int y, input bit blk);
    exp_t e;
    @(negedge vga_clk);
    DrawX = 10'(x); DrawY = 10'(y); blank = blk;
    e = model(x, y, blk);
    exp_q.push_back(e);
    @(posedge vga_clk); #1;
    check("rom_address", 32'(rom_address), 32'(e.addr));
    if (exp_q.size() > 2) check_out(exp_q.pop_front());
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      @(negedge vga_clk);
      blank = 1'b0; DrawX = 10'd1023; DrawY = 10'd1023;
      @(posedge vga_clk); #1;
      check_out(exp_q.pop_front());
    end
  endtask

  task automatic wr(input int sel, input bit en, input int x, input int y, input int spr,
                    input bit fs);
    @(negedge vga_clk);
    slot_bus.slot_wr = 1'b1; slot_bus.slot_sel = 2'(sel); slot_bus.slot_en = en;
    slot_bus.slot_x = 11'(x); slot_bus.slot_y = 10'(y); slot_bus.slot_spr = 2'(spr);
    frame_start = fs; run = 1'b0;
    m_sh_en[sel] = en; m_sh_x[sel] = x; m_sh_y[sel] = y; m_sh_spr[sel] = spr;
    if (fs) model_commit(1'b0, 0);
    @(posedge vga_clk); #1;
    slot_bus.slot_wr = 1'b0; frame_start = 1'b0;
  endtask

  task automatic frame(input bit rn, input int spd);
    @(negedge vga_clk);
    frame_start = 1'b1; run = rn; scroll_speed = 4'(spd);
    model_commit(rn, spd);
    @(posedge vga_clk); #1;
    frame_start = 1'b0; run = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b0;
    frame_start = 1'b0; run = 1'b0; scroll_speed = '0;
    slot_bus.slot_wr = 1'b0; slot_bus.slot_sel = '0; slot_bus.slot_en = 1'b0;
    slot_bus.slot_x = '0; slot_bus.slot_y = '0; slot_bus.slot_spr = '0;
    model_reset();
    repeat (3) @(posedge vga_clk);
    #1;
    check("reset rom_address", 32'(rom_address), 32'd0);
    check("reset pix_valid",   32'(pix_valid),   32'd0);
    check("reset pix_idx",     32'(pix_idx),     32'd0);
    check("reset pix_slot",    32'(pix_slot),    32'd0);
    check("reset scroll_pos",  32'(scroll_pos),  32'd0);
    reset_n = 1'b1;

    // Basic hit, edges, transparency and blanking on slot0 sprite 1.
    wr(0, 1'b1, 100, 200, 1, 1'b0);
    frame(1'b0, 0);
    step(100, 200, 1'b1);
    check("first address", 32'(rom_address), 32'd1024);
    step(131, 231, 1'b1);
    step(132, 200, 1'b1);
    step(99, 200, 1'b1);
    step(107, 200, 1'b1);
    step(100, 200, 1'b0);
    step(110, 232, 1'b1);
    drain();

    // Shadow write without commit must not affect the active set.
    wr(1, 1'b1, 500, 100, 0, 1'b0);
    step(510, 110, 1'b1);
    step(100, 200, 1'b1);
    drain();
    wr(1, 1'b1, 600, 100, 0, 1'b1);
    step(610, 110, 1'b1);
    step(510, 110, 1'b1);
    drain();

    // Priority between overlapping slot0 and slot2.
    wr(0, 1'b1, 40, 40, 0, 1'b0);
    wr(2, 1'b1, 30, 30, 3, 1'b1);
    step(50, 50, 1'b1);
    step(47, 50, 1'b1);
    step(35, 35, 1'b1);
    drain();
    wr(0, 1'b0, 40, 40, 0, 1'b1);
    step(50, 50, 1'b1);
    step(37, 50, 1'b1);
    drain();

    frame(1'b1, 9);
    check("scroll after run", 32'(scroll_pos), 32'(m_scroll));

    // Reset pulse mid-line with a hit in flight.
    step(40, 50, 1'b1);
    step(41, 50, 1'b1);
    @(negedge vga_clk);
    reset_n = 1'b0;
    model_reset();
    exp_q.delete();
    @(posedge vga_clk); #1;
    check("midrst rom_address", 32'(rom_address), 32'd0);
    check("midrst pix_valid",   32'(pix_valid),   32'd0);
    check("midrst pix_idx",     32'(pix_idx),     32'd0);
    check("midrst pix_slot",    32'(pix_slot),    32'd0);
    check("midrst scroll_pos",  32'(scroll_pos),  32'd0);
    reset_n = 1'b1;
    step(40, 50, 1'b1);
    check("post-reset pix_valid", 32'(pix_valid), 32'd0);
    step(100, 200, 1'b1);
    check("post-reset pix_valid 2", 32'(pix_valid), 32'd0);
    step(50, 50, 1'b1);
    drain();

    // Scroll wrap: reach 2046, then +4 wraps to 2.
    for (int k = 0; k < 136; k++) frame(1'b1, 15);
    frame(1'b1, 6);
    check("scroll 2046", 32'(scroll_pos), 32'(m_scroll));
    frame(1'b1, 4);
    check("scroll wrap", 32'(scroll_pos), 32'(m_scroll));
    check("scroll wrap value", 32'(scroll_pos), 32'd2);
    wr(0, 1'b1, 0, 300, 2, 1'b1);
    wr(1, 1'b1, 2045, 400, 3, 1'b1);
    step(0, 300, 1'b1);
    step(29, 310, 1'b1);
    step(30, 310, 1'b1);
    step(20, 405, 1'b1);
    step(27, 405, 1'b1);
    step(2, 331, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
